// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-source round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned SRC_W = 2;

    typedef logic [SRC_W-1:0] src_id_t;

    // Next index in round-robin order, wrapping 3 -> 0.
    function automatic src_id_t next_idx(input src_id_t x);
        return src_id_t'(x + src_id_t'(1));
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first requester after the pointer wins.
import rr_arb_pkg::*;

module rr_pick_4 (
    input  logic [N_SRC-1:0] i_req,
    input  src_id_t          i_ptr,
    output src_id_t          o_win,
    output logic             o_any
);

    src_id_t w_cand;

    // Scan from lowest to highest priority so the nearest requester after i_ptr overwrites.
    always_comb begin
        o_win  = next_idx(i_ptr);
        o_any  = |i_req;
        w_cand = i_ptr;
        for (int k = N_SRC; k >= 1; k--) begin
            w_cand = src_id_t'(i_ptr + src_id_t'(k));
            if (i_req[w_cand]) begin
                o_win = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_4.sv
// Four-source round-robin arbiter with a single registered output stage.
import rr_arb_pkg::*;

module rr_arb_mux_4 #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] in_valid,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_SRC-1:0] in_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    src_id_t      r_last;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    src_id_t      r_out_src;

    src_id_t      w_sel;
    logic         w_any;
    logic         w_load_ok;
    logic         w_accept;
    logic [W-1:0] w_data;

    rr_pick_4 u_pick (
        .i_req (in_valid),
        .i_ptr (r_last),
        .o_win (w_sel),
        .o_any (w_any)
    );

    // The register can take a new word when empty or when it drains this cycle.
    always_comb begin
        w_load_ok = !r_out_valid || out_ready;
        w_accept  = rst_n && w_load_ok && w_any;
        in_ready  = '0;
        if (w_accept) begin
            in_ready = N_SRC'(1) << w_sel;
        end
    end

    // 4:1 data mux driven by the same select exported on sel.
    always_comb begin
        w_data = d0;
        case (w_sel)
            2'd0:    w_data = d0;
            2'd1:    w_data = d1;
            2'd2:    w_data = d2;
            default: w_data = d3;
        endcase
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= src_id_t'(3);
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_src   <= w_sel;
            r_last      <= w_sel;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sel       = w_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Scoreboard bench for rr_arb_mux_4: directed vectors, queue of expected words.
module tb_rr_arb_mux_4;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output words: {src, data}
    logic [2+W-1:0] sb_q[$];

    rr_arb_mux_4 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge, then wait to the falling edge for checks.
    task automatic cyc(input logic r, input logic [3:0] v, input logic rd);
        @(posedge clk);
        #1;
        rst_n     = r;
        in_valid  = v;
        out_ready = rd;
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] s, input logic [W-1:0] d);
        sb_q.push_back({s, d});
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got src %0d data %0h with empty scoreboard", out_src, out_data);
            end else begin
                logic [2+W-1:0] e;
                e = sb_q.pop_front();
                chk("out_src", 32'(out_src), 32'(e[2+W-1:W]));
                chk("out_data", 32'(out_data), 32'(e[W-1:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        cyc(1'b0, 4'b1111, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        chk("rst_in_ready2", 32'(in_ready), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);

        // Fairness: all valid, grant order 0,1,2,3,0
        push(2'd0, 4'd1); push(2'd1, 4'd2); push(2'd2, 4'd3); push(2'd3, 4'd4); push(2'd0, 4'd1);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 4'b1111, 1'b1);
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (j % 4)));
            if (j == 0) chk("first_latency", 32'(out_valid), 32'h0);
            else        chk("rr_out_valid", 32'(out_valid), 32'h1);
        end
        cyc(1'b1, 4'b0000, 1'b1);
        chk("idle_in_ready", 32'(in_ready), 32'h0);

        // Single requester on source 2
        d2 = 4'hA;
        push(2'd2, 4'hA); push(2'd2, 4'hA); push(2'd2, 4'hA);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 4'b0100, 1'b1);
            chk("single_in_ready", 32'(in_ready), 32'h4);
        end
        cyc(1'b1, 4'b0000, 1'b1);
        d2 = 4'd3;

        // Stall: load source 3 into an empty register, then hold with out_ready low
        cyc(1'b1, 4'b1111, 1'b0);
        chk("drained_valid", 32'(out_valid), 32'h0);
        chk("stall_load_ready", 32'(in_ready), 32'h8);
        push(2'd3, 4'd4);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, 4'b1111, 1'b0);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'h4);
            chk("stall_sel", 32'(sel), 32'h0);
        end
        cyc(1'b1, 4'b1111, 1'b1);
        chk("release_in_ready", 32'(in_ready), 32'h1);
        push(2'd0, 4'd1);

        // Wrap-around: set last=3, then sources 0 and 3 valid
        cyc(1'b1, 4'b1000, 1'b1);
        chk("wrap_pre_ready", 32'(in_ready), 32'h8);
        push(2'd3, 4'd4);
        cyc(1'b1, 4'b1001, 1'b1);
        chk("wrap_sel0", 32'(sel), 32'h0);
        chk("wrap_ready0", 32'(in_ready), 32'h1);
        push(2'd0, 4'd1);
        cyc(1'b1, 4'b1001, 1'b1);
        chk("wrap_sel3", 32'(sel), 32'h3);
        push(2'd3, 4'd4);

        // Simultaneous drain and refill from source 1 (this word is discarded by reset below)
        cyc(1'b1, 4'b0010, 1'b1);
        chk("refill_valid_before", 32'(out_valid), 32'h1);
        chk("refill_in_ready", 32'(in_ready), 32'h2);
        cyc(1'b1, 4'b0000, 1'b0);
        chk("refill_valid", 32'(out_valid), 32'h1);
        chk("refill_src", 32'(out_src), 32'h1);
        chk("refill_data", 32'(out_data), 32'h2);

        // Reset while holding a word
        cyc(1'b0, 4'b0000, 1'b0);
        chk("held_before_rst", 32'(out_valid), 32'h1);
        cyc(1'b1, 4'b0110, 1'b1);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_src", 32'(out_src), 32'h0);
        chk("midrst_sel", 32'(sel), 32'h1);
        chk("midrst_in_ready", 32'(in_ready), 32'h2);
        push(2'd1, 4'd2);
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1);
        chk("end_valid", 32'(out_valid), 32'h0);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
